// File: rtl/seq_detect_prg.sv
// seq_detect_prg -- programmable serial sequence detector.
//
// Watches a serial bit stream (ds, qualified by en) for the pattern held in
// the low len bits of setd, most significant of those bits received first.
// A match gives a one-cycle registered pulse on dc. It also advances a
// saturating match counter with a sticky overflow flag.
//
// Ports:
//   clk      in   rising-edge clock
//   clrn     in   asynchronous active-low reset
//   en       in   sample enable; ds is consumed only when en=1
//   ds       in   serial data
//   setd     in   [W-1:0]  pattern, active part setd[len-1:0]
//   len      in   [LW-1:0] active pattern length, legal 1..W
//   mode     in   0 = overlapping, 1 = non-overlapping detection
//   clr_cnt  in   synchronous clear of cnt and ovf (wins over a match)
//   dc       out  registered one-cycle match pulse
//   cnt      out  [CW-1:0] saturating match count
//   ovf      out  sticky: match seen while cnt was all-ones
//   cfg_err  out  combinational, len==0 or len>W
module seq_detect_prg #(
  parameter int W  = 8,
  parameter int LW = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          en,
  input  logic          ds,
  input  logic [W-1:0]  setd,
  input  logic [LW-1:0] len,
  input  logic          mode,
  input  logic          clr_cnt,
  output logic          dc,
  output logic [CW-1:0] cnt,
  output logic          ovf,
  output logic          cfg_err
);

  logic [W-1:0]  hist_r;
  logic [LW-1:0] fill_r;
  logic          dc_r;
  logic [CW-1:0] cnt_r;
  logic          ovf_r;

  logic [W-1:0]  hist_nxt_s;
  logic [LW-1:0] fill_inc_s;
  logic [W-1:0]  mask_s;
  logic          cfg_err_s;
  logic          match_s;

  // Builds a mask with the low l bits set. Mask bits at or above W are never
  // needed, because an out-of-range l is blocked through cfg_err.
  function automatic logic [W-1:0] len_mask(input logic [LW-1:0] l);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) begin
      m[i] = (LW'(i) < l);
    end
    return m;
  endfunction

  // Computes the next history and fill values and the match decision for the current edge.
  always_comb begin
    hist_nxt_s = {hist_r[W-2:0], ds};
    mask_s     = len_mask(len);
    cfg_err_s  = (len == {LW{1'b0}}) || (len > LW'(W));
    if (fill_r == LW'(W)) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + {{(LW-1){1'b0}}, 1'b1};
    end
    // The fill test uses the incremented count, so the bit being sampled now counts.
    match_s = en && !cfg_err_s && (fill_inc_s >= len) &&
              ((hist_nxt_s & mask_s) == (setd & mask_s));
  end

  // Updates the history, fill, pulse and counter registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hist_r <= '0;
      fill_r <= '0;
      dc_r   <= 1'b0;
      cnt_r  <= '0;
      ovf_r  <= 1'b0;
    end else begin
      dc_r <= match_s;
      if (en) begin
        hist_r <= hist_nxt_s;
        // In non-overlapping mode, emptying fill stops a bit from serving two matches.
        if (match_s && mode) begin
          fill_r <= '0;
        end else begin
          fill_r <= fill_inc_s;
        end
      end else begin
        hist_r <= hist_r;
        fill_r <= fill_r;
      end
      if (clr_cnt) begin
        cnt_r <= '0;
        ovf_r <= 1'b0;
      end else if (match_s) begin
        if (&cnt_r) begin
          ovf_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_r <= cnt_r;
        ovf_r <= ovf_r;
      end
    end
  end

  assign dc      = dc_r;
  assign cnt     = cnt_r;
  assign ovf     = ovf_r;
  assign cfg_err = cfg_err_s;

endmodule

// File: tb/tb_seq_detect_prg.sv
// Directed testbench for seq_detect_prg with a scoreboard queue of expected dc values.
module tb_seq_detect_prg;

  localparam int W  = 8;
  localparam int LW = 4;
  localparam int CW = 4;

  logic          clk;
  logic          clrn;
  logic          en;
  logic          ds;
  logic [W-1:0]  setd;
  logic [LW-1:0] len;
  logic          mode;
  logic          clr_cnt;
  logic          dc;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    logic  dc_exp;
  } exp_t;
  exp_t exp_q[$];

  seq_detect_prg #(.W(W), .LW(LW), .CW(CW)) dut (
    .clk     (clk),
    .clrn    (clrn),
    .en      (en),
    .ds      (ds),
    .setd    (setd),
    .len     (len),
    .mode    (mode),
    .clr_cnt (clr_cnt),
    .dc      (dc),
    .cnt     (cnt),
    .ovf     (ovf),
    .cfg_err (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, record the expected dc, clock it, then pop and compare.
  task automatic step(input string tag, input logic e, input logic d, input logic exp_dc);
    exp_t item;
    en = e;
    ds = d;
    item.tag    = tag;
    item.dc_exp = exp_dc;
    exp_q.push_back(item);
    @(posedge clk);
    #1;
    item = exp_q.pop_front();
    chk(item.tag, {31'd0, dc}, {31'd0, item.dc_exp});
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    en = 1'b0;
    #2;
    clrn = 1'b0;
    #1;
    chk({tag, "_rst_cnt"}, {28'd0, cnt}, 32'd0);
    chk({tag, "_rst_dc"}, {31'd0, dc}, 32'd0);
    chk({tag, "_rst_ovf"}, {31'd0, ovf}, 32'd0);
    #1;
    clrn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Feed the eight bits of A5 (MSB first); dc expected only after the last bit when hit=1.
  task automatic stream_a5(input string tag, input logic hit);
    logic [7:0] p;
    p = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      step(tag, 1'b1, p[i], (i == 0) ? hit : 1'b0);
    end
  endtask

  initial begin
    logic [6:0] s7;
    clrn    = 1'b0;
    en      = 1'b0;
    ds      = 1'b0;
    setd    = 8'hA5;
    len     = 4'd8;
    mode    = 1'b0;
    clr_cnt = 1'b0;
    #12;
    chk("reset_dc", {31'd0, dc}, 32'd0);
    chk("reset_cnt", {28'd0, cnt}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    chk("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // Full 8-bit A5 match
    stream_a5("a5", 1'b1);
    step("a5_idle", 1'b0, 1'b1, 1'b0);
    chk("a5_cnt", {28'd0, cnt}, 32'd1);

    // en gaps between bit 4 and bit 5
    do_reset("gap");
    step("gap_b1", 1'b1, 1'b1, 1'b0);
    step("gap_b2", 1'b1, 1'b0, 1'b0);
    step("gap_b3", 1'b1, 1'b1, 1'b0);
    step("gap_b4", 1'b1, 1'b0, 1'b0);
    step("gap_off1", 1'b0, 1'b1, 1'b0);
    step("gap_off2", 1'b0, 1'b0, 1'b0);
    step("gap_off3", 1'b0, 1'b1, 1'b0);
    step("gap_b5", 1'b1, 1'b0, 1'b0);
    step("gap_b6", 1'b1, 1'b1, 1'b0);
    step("gap_b7", 1'b1, 1'b0, 1'b0);
    step("gap_b8", 1'b1, 1'b1, 1'b1);
    step("gap_idle", 1'b0, 1'b0, 1'b0);
    chk("gap_cnt", {28'd0, cnt}, 32'd1);

    // Overlapping detection, pattern 1011
    do_reset("ovl");
    len  = 4'd4;
    setd = 8'h0B;
    mode = 1'b0;
    s7   = 7'b1011011;
    for (int i = 6; i >= 0; i--) begin
      step("ovl_bit", 1'b1, s7[i], (i == 3 || i == 0) ? 1'b1 : 1'b0);
    end
    chk("ovl_cnt", {28'd0, cnt}, 32'd2);

    // Non-overlapping detection, same stream
    do_reset("novl");
    mode = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      step("novl_bit", 1'b1, s7[i], (i == 3) ? 1'b1 : 1'b0);
    end
    chk("novl_cnt", {28'd0, cnt}, 32'd1);

    // Reset in the middle of a partial match
    do_reset("rstp");
    mode = 1'b0;
    len  = 4'd8;
    setd = 8'hA5;
    step("rstp_b1", 1'b1, 1'b1, 1'b0);
    step("rstp_b2", 1'b1, 1'b0, 1'b0);
    step("rstp_b3", 1'b1, 1'b1, 1'b0);
    do_reset("rstp_mid");
    step("rstp_b4", 1'b1, 1'b0, 1'b0);
    step("rstp_b5", 1'b1, 1'b0, 1'b0);
    step("rstp_b6", 1'b1, 1'b1, 1'b0);
    step("rstp_b7", 1'b1, 1'b0, 1'b0);
    step("rstp_b8", 1'b1, 1'b1, 1'b0);
    stream_a5("rstp_full", 1'b1);
    chk("rstp_cnt", {28'd0, cnt}, 32'd1);

    // Illegal lengths block detection, legal length resumes it
    do_reset("cfg");
    len = 4'd0;
    #1;
    chk("cfg_len0_err", {31'd0, cfg_err}, 32'd1);
    stream_a5("cfg_len0", 1'b0);
    len = 4'd9;
    #1;
    chk("cfg_len9_err", {31'd0, cfg_err}, 32'd1);
    stream_a5("cfg_len9", 1'b0);
    len = 4'd8;
    #1;
    chk("cfg_len8_err", {31'd0, cfg_err}, 32'd0);
    stream_a5("cfg_len8", 1'b1);
    chk("cfg_cnt", {28'd0, cnt}, 32'd1);

    // Counter saturation, overflow and clear priority
    do_reset("sat");
    len  = 4'd1;
    setd = 8'h01;
    for (int i = 1; i <= 17; i++) begin
      step("sat_bit", 1'b1, 1'b1, 1'b1);
      chk("sat_cnt", {28'd0, cnt}, (i >= 15) ? 32'd15 : 32'(i));
      chk("sat_ovf", {31'd0, ovf}, (i >= 16) ? 32'd1 : 32'd0);
    end
    clr_cnt = 1'b1;
    step("sat_clr_dc", 1'b1, 1'b1, 1'b1);
    clr_cnt = 1'b0;
    chk("sat_clr_cnt", {28'd0, cnt}, 32'd0);
    chk("sat_clr_ovf", {31'd0, ovf}, 32'd0);
    step("sat_zero", 1'b1, 1'b0, 1'b0);
    chk("sat_zero_cnt", {28'd0, cnt}, 32'd0);
    step("sat_again", 1'b1, 1'b1, 1'b1);
    chk("sat_again_cnt", {28'd0, cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
